qram_bank_ctrl: RTL and testbench

Parametrised single-port quantum-register RAM bank with a valid/ready command interface, replacing the fixed 1-bit QRAM macro. Supports masked writes, pipelined reads with configurable latency, and a hardware clear sweep run after reset or on request. Sits between the QRAM command sequencer and the bit-level QRAM storage in the digit-supply domain.

---
 rtl/qram_bank_ctrl.sv | 120 ++++++++++++
 tb/tb_qram_bank_ctrl.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/qram_bank_ctrl.sv
// qram_bank_ctrl
//   Single-port quantum-register RAM bank with a valid/ready command port.
//   It supports masked writes and pipelined reads, with a read latency of
//   READ_LATENCY cycles. A clear sweep zeroes the storage. The sweep runs
//   after reset (when CLEAR_ON_RESET is set) or on a ClearReq seen in IDLE.
//
// Ports
//   Clock     sole clock, rising edge
//   ResetN    async active-low reset (storage itself is not reset)
//   CmdValid  command present
//   CmdReady  command accepted on CmdValid & CmdReady at a rising edge
//   CmdWrite  1 = write, 0 = read
//   CmdAddr   word address
//   CmdWData  write data
//   CmdWMask  per-bit write enable
//   ClearReq  level request for a clear sweep, honoured only in IDLE
//   RdValid   one-cycle pulse, RdData valid
//   RdData    read data, holds last value between pulses
//   Busy      sweep running or read in flight
module qram_bank_ctrl #(
   parameter int DATA_WIDTH     = 8,
   parameter int ADDR_WIDTH     = 4,
   parameter int READ_LATENCY   = 2,
   parameter int CLEAR_ON_RESET = 1
) (
   input  logic                  Clock,
   input  logic                  ResetN,
   input  logic                  CmdValid,
   output logic                  CmdReady,
   input  logic                  CmdWrite,
   input  logic [ADDR_WIDTH-1:0] CmdAddr,
   input  logic [DATA_WIDTH-1:0] CmdWData,
   input  logic [DATA_WIDTH-1:0] CmdWMask,
   input  logic                  ClearReq,
   output logic                  RdValid,
   output logic [DATA_WIDTH-1:0] RdData,
   output logic                  Busy
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;

   typedef enum logic {stClear, stIdle} state_t;
   localparam state_t RST_STATE = (CLEAR_ON_RESET != 0) ? stClear : stIdle;

   state_t                  state;
   logic [ADDR_WIDTH-1:0]   ptr;
   logic [DATA_WIDTH-1:0]   mem [DEPTH];

   logic                    wrAcc, rdAcc;

   // Read pipeline: stage 0 captures mem at the accepting edge; the last
   // stage drives the outputs. Stage data only loads with a valid token,
   // so RdData holds its last value between responses.
   logic [READ_LATENCY-1:0]                 vldPipe;
   logic [READ_LATENCY-1:0][DATA_WIDTH-1:0] datPipe;
   logic [READ_LATENCY-1:0]                 stgVldIn;
   logic [READ_LATENCY-1:0][DATA_WIDTH-1:0] stgDatIn;

   // ResetN gates CmdReady so nothing is accepted while reset is held,
   // even when the reset state is IDLE.
   assign CmdReady = ResetN & (state == stIdle) & ~ClearReq;
   assign wrAcc    = CmdValid & CmdReady & CmdWrite;
   assign rdAcc    = CmdValid & CmdReady & ~CmdWrite;

   always_ff @(posedge Clock or negedge ResetN) begin
      if (!ResetN) begin
         state <= RST_STATE;
         ptr   <= '0;
      end else begin
         case (state)
            stClear: begin
               ptr <= ptr + 1'b1;          // wraps to 0 after the last word
               if (ptr == '1) state <= stIdle;
            end
            default: begin
               if (ClearReq) begin
                  state <= stClear;
                  ptr   <= '0;
               end
            end
         endcase
      end
   end

   // Storage has no reset; only the sweep zeroes it.
   always_ff @(posedge Clock) begin
      if (state == stClear)
         mem[ptr] <= '0;
      else if (wrAcc)
         mem[CmdAddr] <= (mem[CmdAddr] & ~CmdWMask) | (CmdWData & CmdWMask);
   end

   always_comb begin
      stgVldIn    = '0;
      stgDatIn    = '0;
      stgVldIn[0] = rdAcc;
      stgDatIn[0] = mem[CmdAddr];
      for (int g = 1; g < READ_LATENCY; g++) begin
         stgVldIn[g] = vldPipe[g-1];
         stgDatIn[g] = datPipe[g-1];
      end
   end

   // Reset drops in-flight tokens, so discarded reads never pulse RdValid.
   always_ff @(posedge Clock or negedge ResetN) begin
      if (!ResetN) begin
         vldPipe <= '0;
         datPipe <= '0;
      end else begin
         vldPipe <= stgVldIn;
         for (int g = 0; g < READ_LATENCY; g++)
            if (stgVldIn[g]) datPipe[g] <= stgDatIn[g];
      end
   end

   assign RdValid = vldPipe[READ_LATENCY-1];
   assign RdData  = datPipe[READ_LATENCY-1];
   assign Busy    = (state == stClear) | (|vldPipe);

endmodule

// File: tb/tb_qram_bank_ctrl.sv
// Bench for qram_bank_ctrl.
//   Instance A: READ_LATENCY=2, CLEAR_ON_RESET=1
//   Instance B: READ_LATENCY=1, CLEAR_ON_RESET=0
// The model keeps a word array, a remaining-sweep count, and expected
// responses keyed by the cycle in which they must appear. Every cycle is
// compared at the falling edge, with literal checks at the key points.
module tb_qram_bank_ctrl;
   localparam int LA = 2;
   localparam int LB = 1;

   logic       Clock, ResetN;
   logic       cvA, cwA, crqA, rdyA, rvA, bzA;
   logic [3:0] caA;
   logic [7:0] cdA, cmA, rdA;
   logic       cvB, cwB, crqB, rdyB, rvB, bzB;
   logic [3:0] caB;
   logic [7:0] cdB, cmB, rdB;

   qram_bank_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .READ_LATENCY(LA), .CLEAR_ON_RESET(1)) dutA (
      .Clock(Clock), .ResetN(ResetN), .CmdValid(cvA), .CmdReady(rdyA), .CmdWrite(cwA),
      .CmdAddr(caA), .CmdWData(cdA), .CmdWMask(cmA), .ClearReq(crqA),
      .RdValid(rvA), .RdData(rdA), .Busy(bzA));

   qram_bank_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .READ_LATENCY(LB), .CLEAR_ON_RESET(0)) dutB (
      .Clock(Clock), .ResetN(ResetN), .CmdValid(cvB), .CmdReady(rdyB), .CmdWrite(cwB),
      .CmdAddr(caB), .CmdWData(cdB), .CmdWMask(cmB), .ClearReq(crqB),
      .RdValid(rvB), .RdData(rdB), .Busy(bzB));

   always #5 Clock = ~Clock;

   int nVec, nBad, edgeN, n;
   int clrA, clrB, dueA, dueB;
   logic [7:0] memA [16];
   logic [7:0] memB [16];
   logic [7:0] expA [int];
   logic [7:0] expB [int];
   logic [7:0] lastA, lastB;

   task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
      nVec++;
      if (act !== exp) begin
         nBad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, edgeN);
      end
   endtask

   task automatic modelReset();
      ResetN = 0;
      expA.delete(); expB.delete();
      dueA = -1; dueB = -1;
      lastA = 0; lastB = 0;
      clrA = 16; clrB = 0;
      for (int i = 0; i < 16; i++) memA[i] = 8'h00;
   endtask

   // Applies one rising edge to the model using the inputs held across it.
   task automatic edgeModel();
      if (!ResetN) return;
      edgeN++;
      if (clrA > 0) clrA--;
      else if (crqA) begin
         clrA = 16;
         for (int i = 0; i < 16; i++) memA[i] = 8'h00;
      end else if (cvA) begin
         if (cwA) memA[caA] = (memA[caA] & ~cmA) | (cdA & cmA);
         else begin expA[edgeN + LA - 1] = memA[caA]; dueA = edgeN + LA - 1; end
      end
      if (clrB > 0) clrB--;
      else if (crqB) begin
         clrB = 16;
         for (int i = 0; i < 16; i++) memB[i] = 8'h00;
      end else if (cvB) begin
         if (cwB) memB[caB] = (memB[caB] & ~cmB) | (cdB & cmB);
         else begin expB[edgeN + LB - 1] = memB[caB]; dueB = edgeN + LB - 1; end
      end
      if (expA.exists(edgeN)) lastA = expA[edgeN];
      if (expB.exists(edgeN)) lastB = expB[edgeN];
   endtask

   task automatic chk();
      cmp("A.CmdReady", rdyA, ResetN && clrA == 0 && !crqA);
      cmp("A.RdValid",  rvA,  ResetN && expA.exists(edgeN));
      cmp("A.RdData",   rdA,  lastA);
      cmp("A.Busy",     bzA,  clrA > 0 || dueA >= edgeN);
      cmp("B.CmdReady", rdyB, ResetN && clrB == 0 && !crqB);
      cmp("B.RdValid",  rvB,  ResetN && expB.exists(edgeN));
      cmp("B.RdData",   rdB,  lastB);
      cmp("B.Busy",     bzB,  clrB > 0 || dueB >= edgeN);
   endtask

   task automatic tick();
      @(posedge Clock);
      edgeModel();
      @(negedge Clock);
      chk();
   endtask

   task automatic opA(input logic w, input logic [3:0] a, input logic [7:0] d, input logic [7:0] m);
      cvA = 1; cwA = w; caA = a; cdA = d; cmA = m;
      tick();
   endtask

   task automatic waitReadyA(input string nm);
      n = 0;
      while (!rdyA && n < 40) begin tick(); n++; end
      cmp(nm, n, 16);
   endtask

   initial begin
      Clock = 0;
      cvA = 0; cwA = 0; caA = 0; cdA = 0; cmA = 0; crqA = 0;
      cvB = 0; cwB = 0; caB = 0; cdB = 0; cmB = 0; crqB = 0;
      nVec = 0; nBad = 0; edgeN = 0;
      for (int i = 0; i < 16; i++) memB[i] = 8'h00;
      modelReset();
      tick(); tick();
      ResetN = 1;
      #1;
      cmp("B.readyAfterReset", rdyB, 1);
      cmp("A.notReadyInSweep", rdyA, 0);
      waitReadyA("A.resetSweepLen");

      // Instance B: write then read the next cycle, with one-cycle latency.
      cvB = 1; cwB = 1; caB = 9; cdB = 8'h42; cmB = 8'hFF; tick();
      cwB = 0; tick();
      cmp("B.rd9Valid", rvB, 1);
      cmp("B.rd9Data", rdB, 8'h42);
      cvB = 0; tick();

      // The whole array must read back zero after the sweep.
      for (int i = 0; i < 16; i++) opA(0, 4'(i), 8'h00, 8'h00);
      cvA = 0; tick(); tick(); tick();

      // Masked writes, including an all-zero mask, then the latency check.
      opA(1, 3, 8'hA5, 8'hFF);
      opA(1, 3, 8'h0F, 8'h0F);
      opA(1, 3, 8'hFF, 8'h00);
      opA(0, 3, 8'h00, 8'h00);
      cvA = 0;
      cmp("A.rd3NotYet", rvA, 0);
      tick();
      cmp("A.rd3Valid", rvA, 1);
      cmp("A.rd3Data", rdA, 8'hAF);
      tick();
      cmp("A.rd3Hold", rdA, 8'hAF);

      // Back-to-back reads.
      for (int i = 0; i < 8; i++) opA(1, 4'(i), 8'(i * 17), 8'hFF);
      for (int i = 0; i < 8; i++) opA(0, 4'(i), 8'h00, 8'h00);
      cvA = 0; tick();
      cmp("A.lastB2BData", rdA, 8'h77);
      tick(); tick();

      // Clear request while a read is in flight and another one is pending.
      opA(1, 5, 8'h3C, 8'hFF);
      opA(0, 5, 8'h00, 8'h00);
      crqA = 1; tick();
      cmp("A.inflightValid", rvA, 1);
      cmp("A.inflightData", rdA, 8'h3C);
      crqA = 0;
      waitReadyA("A.clearReqLen");
      tick();
      cvA = 0; tick();
      cmp("A.postClearValid", rvA, 1);
      cmp("A.postClearData", rdA, 8'h00);

      // Reset at sweep cycle 7: the sweep restarts at full length.
      crqA = 1; tick(); crqA = 0;
      repeat (7) tick();
      modelReset(); tick();
      ResetN = 1;
      waitReadyA("A.restartSweepLen");

      // Reset with a read in flight: the response is dropped.
      opA(1, 6, 8'h99, 8'hFF);
      opA(0, 6, 8'h00, 8'h00);
      cvA = 0;
      modelReset();
      #1;
      cmp("A.rstRdValid", rvA, 0);
      cmp("A.rstRdData", rdA, 8'h00);
      tick(); tick();
      ResetN = 1;
      waitReadyA("A.postResetSweepLen");
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end
endmodule
